// File: rtl/ec_scalar_mul.sv
// secp256k1 scalar multiplier R = k*P: MSB-first double-and-add that sequences an
// external affine point adder over the pa_* start/done handshake.
module ec_scalar_mul #(
    parameter bit          CONST_TIME = 1'b1,
    parameter int unsigned TIMEOUT    = 0,
    parameter int unsigned REQ_GAP    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] k,
    input  logic [255:0] px,
    input  logic [255:0] py,
    input  logic         pinf,
    output logic         busy,
    output logic         done,
    output logic [255:0] rx,
    output logic [255:0] ry,
    output logic         rinf,
    output logic         err,
    output logic         pa_start,
    output logic [255:0] pa_x1,
    output logic [255:0] pa_y1,
    output logic         pa_inf1,
    output logic [255:0] pa_x2,
    output logic [255:0] pa_y2,
    output logic         pa_inf2,
    input  logic         pa_done,
    input  logic [255:0] pa_x3,
    input  logic [255:0] pa_y3,
    input  logic         pa_inf3
);

    localparam logic [7:0]  GAP_LOAD = 8'(REQ_GAP);
    localparam logic [31:0] WD_LAST  = 32'(TIMEOUT) - 32'd1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_DBL_REQ, S_DBL_WAIT, S_ADD_REQ, S_ADD_WAIT, S_NEXT, S_FIN, S_ERR
    } state_t;

    state_t        state_r;
    logic [255:0]  k_r;
    logic [255:0]  px_r;
    logic [255:0]  py_r;
    logic          pinf_r;
    logic [255:0]  acc_x_r;
    logic [255:0]  acc_y_r;
    logic          acc_inf_r;
    logic [7:0]    idx_r;
    logic [7:0]    gap_r;
    logic [31:0]   wd_r;
    logic          k_bit_s;
    logic          wd_hit_s;

    assign k_bit_s  = k_r[idx_r];
    assign wd_hit_s = (32'(TIMEOUT) != 32'd0) && (wd_r == WD_LAST);

    // Sequencer: loop control, adder handshake, watchdog and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            k_r       <= 256'd0;
            px_r      <= 256'd0;
            py_r      <= 256'd0;
            pinf_r    <= 1'b0;
            acc_x_r   <= 256'd0;
            acc_y_r   <= 256'd0;
            acc_inf_r <= 1'b1;
            idx_r     <= 8'd0;
            gap_r     <= 8'd0;
            wd_r      <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx        <= 256'd0;
            ry        <= 256'd0;
            rinf      <= 1'b0;
            err       <= 1'b0;
            pa_start  <= 1'b0;
            pa_x1     <= 256'd0;
            pa_y1     <= 256'd0;
            pa_inf1   <= 1'b0;
            pa_x2     <= 256'd0;
            pa_y2     <= 256'd0;
            pa_inf2   <= 1'b0;
        end else begin
            done     <= 1'b0;
            pa_start <= 1'b0;
            if (gap_r != 8'd0) begin
                gap_r <= gap_r - 8'd1;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        k_r     <= k;
                        px_r    <= px;
                        py_r    <= py;
                        pinf_r  <= pinf;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        state_r <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc_x_r   <= 256'd0;
                    acc_y_r   <= 256'd0;
                    acc_inf_r <= 1'b1;
                    idx_r     <= 8'd255;
                    gap_r     <= 8'd0;
                    state_r   <= S_DBL_REQ;
                end
                // gap_r<=1 here means REQ_GAP idle cycles have already elapsed since pa_done
                S_DBL_REQ, S_ADD_REQ: begin
                    if (gap_r <= 8'd1) begin
                        pa_start <= 1'b1;
                        pa_x1    <= acc_x_r;
                        pa_y1    <= acc_y_r;
                        pa_inf1  <= acc_inf_r;
                        pa_x2    <= (state_r == S_DBL_REQ) ? acc_x_r : px_r;
                        pa_y2    <= (state_r == S_DBL_REQ) ? acc_y_r : py_r;
                        pa_inf2  <= (state_r == S_DBL_REQ) ? acc_inf_r : pinf_r;
                        wd_r     <= 32'd0;
                        state_r  <= (state_r == S_DBL_REQ) ? S_DBL_WAIT : S_ADD_WAIT;
                    end
                end
                S_DBL_WAIT, S_ADD_WAIT: begin
                    if (pa_done) begin
                        gap_r <= GAP_LOAD;
                        if (state_r == S_DBL_WAIT || k_bit_s) begin
                            acc_x_r   <= pa_x3;
                            acc_y_r   <= pa_y3;
                            acc_inf_r <= pa_inf3;
                        end
                        if (state_r == S_DBL_WAIT && (CONST_TIME || k_bit_s)) begin
                            state_r <= S_ADD_REQ;
                        end else begin
                            state_r <= S_NEXT;
                        end
                    end else if (wd_hit_s) begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        rinf    <= 1'b1;
                        rx      <= 256'd0;
                        ry      <= 256'd0;
                        state_r <= S_ERR;
                    end else begin
                        wd_r <= wd_r + 32'd1;
                    end
                end
                S_NEXT: begin
                    if (idx_r == 8'd0) begin
                        rx      <= acc_inf_r ? 256'd0 : acc_x_r;
                        ry      <= acc_inf_r ? 256'd0 : acc_y_r;
                        rinf    <= acc_inf_r;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= S_FIN;
                    end else begin
                        idx_r   <= idx_r - 8'd1;
                        state_r <= S_DBL_REQ;
                    end
                end
                S_FIN, S_ERR: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
